// File: rtl/onchip_mem_pkg.sv
// -----------------------------------------------------------------------------
// onchip_mem_pkg
// Shared definitions for the on-chip memory user logic (write side).
//   MEM_ADDR_W / MEM_DATA_W / MEM_BE_W / BYTE_ADDR_W : memory port geometry
//   wr_state_e : write-job FSM state encoding
//   mask()     : byte-enable vector covering lanes lo .. lo+n-1
//   word_swap(): reverse the order of the eight 32-bit words of a beat
// -----------------------------------------------------------------------------
package onchip_mem_pkg;

  localparam int MEM_ADDR_W  = 13;
  localparam int MEM_DATA_W  = 256;
  localparam int MEM_BE_W    = 32;
  localparam int BYTE_ADDR_W = 18;
  localparam int LANE_W      = 5;
  localparam int LEN_W       = 32;
  localparam int WORDS       = MEM_DATA_W / 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

  // Enable bit i is set when lo <= i < lo+n; n may be 32, hence 6-bit inputs.
  function automatic logic [MEM_BE_W-1:0] mask(input logic [5:0] lo, input logic [5:0] n);
    logic [6:0] hi;
    logic [MEM_BE_W-1:0] be;
    hi = {1'b0, lo} + {1'b0, n};
    be = {MEM_BE_W{1'b0}};
    for (int i = 0; i < MEM_BE_W; i++) begin
      if ((7'(i) >= {1'b0, lo}) && (7'(i) < hi)) begin
        be[i] = 1'b1;
      end else begin
        be[i] = 1'b0;
      end
    end
    return be;
  endfunction

  // Input word 7 ([255:224]) lands in memory word 0 ([31:0]), and so on.
  function automatic logic [MEM_DATA_W-1:0] word_swap(input logic [MEM_DATA_W-1:0] d);
    logic [MEM_DATA_W-1:0] s;
    s = {MEM_DATA_W{1'b0}};
    for (int w = 0; w < WORDS; w++) begin
      s[32*w +: 32] = d[32*(WORDS-1-w) +: 32];
    end
    return s;
  endfunction

endpackage

// File: rtl/onchip_mem_wr_fifo.sv
// -----------------------------------------------------------------------------
// onchip_mem_wr_fifo
// Synchronous show-ahead FIFO buffering incoming write beats.
//   clk, rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   push, push_data : write a beat (ignored while full)
//   pop        : discard the head beat (ignored while empty)
//   head_data  : current head beat, valid whenever empty is low
//   full, empty: registered occupancy flags
// -----------------------------------------------------------------------------
module onchip_mem_wr_fifo
  import onchip_mem_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic [PTR_W:0]    count_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // Flags are registered, so a push on a full FIFO is refused even if a pop
  // happens in the same cycle.
  assign push_ok_s = push & ~full_r;
  assign pop_ok_s  = pop & ~empty_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign head_data = mem_r[rd_ptr_r];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
      2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Beat storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == (PTR_W+1)'(DEPTH));
      empty_r <= (count_nxt_s == (PTR_W+1)'(0));
    end
  end

endmodule

// File: rtl/onchip_mem_usr_writer.sv
// -----------------------------------------------------------------------------
// onchip_mem_usr_writer
// Write-side user logic for the on-chip RAM: takes a byte-granular job (start
// byte address + byte count) and a stream of 256-bit beats, and issues one
// 256-bit word write per beat with byte enables trimmed to the job window.
// Build option: ONCHIP_MEM_WR_SWAP_EN reverses the 32-bit word order of each
// beat on its way to memory; undefined, data passes through unchanged.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   onchip_mem_start_addr_in[17:0] job byte start address
//   to_write_byte_in[31:0]         job byte count
//   onchip_mem_write_start_in      job start pulse (honoured in IDLE only)
//   onchip_mem_write_done_out      job complete pulse
//   write_data_in / _valid_in      incoming beat stream
//   write_data_ready_out           beat buffer not full
//   onchip_mem_*                   memory port (registered)
// -----------------------------------------------------------------------------
module onchip_mem_usr_writer
  import onchip_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BYTE_ADDR_W-1:0] onchip_mem_start_addr_in,
  input  logic [LEN_W-1:0]       to_write_byte_in,
  input  logic                   onchip_mem_write_start_in,
  output logic                   onchip_mem_write_done_out,
  input  logic [MEM_DATA_W-1:0]  write_data_in,
  input  logic                   write_data_valid_in,
  output logic                   write_data_ready_out,
  output logic                   onchip_mem_chip_select,
  output logic                   onchip_mem_clk_ena,
  output logic                   onchip_mem_write,
  output logic [MEM_ADDR_W-1:0]  onchip_mem_addr,
  output logic [MEM_DATA_W-1:0]  onchip_mem_write_data,
  output logic [MEM_BE_W-1:0]    onchip_mem_byteenable
);

  wr_state_e             state_r;
  wr_state_e             next_state_s;
  logic [MEM_ADDR_W-1:0] addr_r;
  logic [LANE_W-1:0]     off_r;
  logic [LEN_W-1:0]      left_r;
  logic                  first_r;

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [MEM_DATA_W-1:0] fifo_head_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  done_nxt_s;

  logic [5:0]            lo_s;
  logic [5:0]            avail_s;
  logic [5:0]            n_s;
  logic [LEN_W-1:0]      left_nxt_s;
  logic                  last_s;
  logic [MEM_BE_W-1:0]   be_s;
  logic [MEM_DATA_W-1:0] mem_data_s;

  assign onchip_mem_clk_ena   = 1'b1;
  assign write_data_ready_out = ~fifo_full_s;
  assign push_s               = write_data_valid_in & ~fifo_full_s;

  onchip_mem_wr_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (MEM_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (write_data_in),
    .pop       (pop_s),
    .head_data (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

`ifdef ONCHIP_MEM_WR_SWAP_EN
  assign mem_data_s = word_swap(fifo_head_s);
`else
  assign mem_data_s = fifo_head_s;
`endif

  // Byte window of the current beat: the start offset only applies to the
  // first beat; n never exceeds left, so left cannot underflow.
  always_comb begin
    lo_s       = 6'd0;
    avail_s    = 6'd32;
    n_s        = 6'd0;
    left_nxt_s = left_r;
    last_s     = 1'b0;
    be_s       = {MEM_BE_W{1'b0}};
    if (first_r) begin
      lo_s = {1'b0, off_r};
    end else begin
      lo_s = 6'd0;
    end
    avail_s = 6'd32 - lo_s;
    if (left_r < {26'd0, avail_s}) begin
      n_s = left_r[5:0];
    end else begin
      n_s = avail_s;
    end
    left_nxt_s = left_r - {26'd0, n_s};
    last_s     = (left_nxt_s == 32'd0);
    be_s       = mask(lo_s, n_s);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (onchip_mem_write_start_in) begin
          if (to_write_byte_in == 32'd0) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_WRITE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (pop_s && last_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_WRITE;
        end
      end
      ST_DONE:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: pop/write while WRITE has a beat, done after DONE.
  always_comb begin
    pop_s      = 1'b0;
    done_nxt_s = 1'b0;
    case (state_r)
      ST_WRITE: pop_s      = ~fifo_empty_s;
      ST_DONE:  done_nxt_s = 1'b1;
      default: begin
        pop_s      = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Job context: latched on an accepted start, advanced on every write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= {MEM_ADDR_W{1'b0}};
      off_r   <= {LANE_W{1'b0}};
      left_r  <= {LEN_W{1'b0}};
      first_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && onchip_mem_write_start_in) begin
      addr_r  <= onchip_mem_start_addr_in[BYTE_ADDR_W-1:LANE_W];
      off_r   <= onchip_mem_start_addr_in[LANE_W-1:0];
      left_r  <= to_write_byte_in;
      first_r <= 1'b1;
    end else if (pop_s) begin
      addr_r  <= addr_r + 13'd1;
      left_r  <= left_nxt_s;
      first_r <= 1'b0;
    end
  end

  // Registered memory port and done pulse; address/data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onchip_mem_write          <= 1'b0;
      onchip_mem_chip_select    <= 1'b0;
      onchip_mem_addr           <= {MEM_ADDR_W{1'b0}};
      onchip_mem_write_data     <= {MEM_DATA_W{1'b0}};
      onchip_mem_byteenable     <= {MEM_BE_W{1'b0}};
      onchip_mem_write_done_out <= 1'b0;
    end else begin
      onchip_mem_write          <= pop_s;
      onchip_mem_chip_select    <= pop_s;
      onchip_mem_write_done_out <= done_nxt_s;
      if (pop_s) begin
        onchip_mem_addr       <= addr_r;
        onchip_mem_write_data <= mem_data_s;
        onchip_mem_byteenable <= be_s;
      end else begin
        onchip_mem_byteenable <= {MEM_BE_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_onchip_mem_usr_writer.sv
// -----------------------------------------------------------------------------
// tb_onchip_mem_usr_writer
// Scoreboard bench: every expected memory write (address, byte enable, data)
// is queued when the job is set up and compared when the write strobe appears.
// -----------------------------------------------------------------------------
module tb_onchip_mem_usr_writer;

  logic         clk;
  logic         rst_n;
  logic [17:0]  start_addr;
  logic [31:0]  to_write;
  logic         start;
  logic         done;
  logic [255:0] wdata;
  logic         wvalid;
  logic         wready;
  logic         cs;
  logic         clk_ena;
  logic         mwrite;
  logic [12:0]  maddr;
  logic [255:0] mdata;
  logic [31:0]  mbe;

  onchip_mem_usr_writer #(.FIFO_DEPTH(16)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .onchip_mem_start_addr_in  (start_addr),
    .to_write_byte_in          (to_write),
    .onchip_mem_write_start_in (start),
    .onchip_mem_write_done_out (done),
    .write_data_in             (wdata),
    .write_data_valid_in       (wvalid),
    .write_data_ready_out      (wready),
    .onchip_mem_chip_select    (cs),
    .onchip_mem_clk_ena        (clk_ena),
    .onchip_mem_write          (mwrite),
    .onchip_mem_addr           (maddr),
    .onchip_mem_write_data     (mdata),
    .onchip_mem_byteenable     (mbe)
  );

  typedef struct {
    logic [12:0]  addr;
    logic [31:0]  be;
    logic [255:0] data;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] beat_q[$];
  exp_t         mon_e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int last_wr_cyc = 0;
  int first_wr_cyc = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int wr_base = 0;
  int done_base = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_data(input logic [255:0] b);
    logic [255:0] r;
`ifdef ONCHIP_MEM_WR_SWAP_EN
    for (int w = 0; w < 8; w++) r[32*w +: 32] = b[32*(7-w) +: 32];
`else
    r = b;
`endif
    return r;
  endfunction

  function automatic logic [255:0] rand_beat();
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[32*w +: 32] = $urandom;
    return b;
  endfunction

  // Monitor: compare every write strobe against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && mwrite) begin
      if (wr_cnt == wr_base) first_wr_cyc = cyc;
      wr_cnt++;
      last_wr_cyc = cyc;
      check_value("wr_expected", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_value("wr_addr", 256'(maddr), 256'(mon_e.addr));
        check_value("wr_be", 256'(mbe), 256'(mon_e.be));
        check_value("wr_data", mdata, mon_e.data);
        check_value("wr_cs", 256'(cs), 256'(1));
      end
    end
    if (rst_n && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Offer one random beat for up to 3 cycles; model it only if accepted.
  task automatic send_beat(output bit ok);
    logic [255:0] b;
    logic r;
    b = rand_beat();
    wdata = b;
    wvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      r = wready;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    wvalid = 1'b0;
    if (ok) beat_q.push_back(b);
  endtask

  task automatic send_beats(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      send_beat(ok);
      check_value("beat_accept", 256'(ok), 256'(1));
    end
  endtask

  task automatic exp_wr(input logic [12:0] a, input logic [31:0] be);
    exp_t e;
    check_value("model_beat", 256'(beat_q.size() != 0), 256'(1));
    if (beat_q.size() != 0) begin
      e.addr = a;
      e.be = be;
      e.data = exp_data(beat_q.pop_front());
      exp_q.push_back(e);
    end
  endtask

  task automatic start_job(input logic [17:0] a, input logic [31:0] n);
    start_addr = a;
    to_write = n;
    start = 1'b1;
    start_cyc = cyc;
    wr_base = wr_cnt;
    done_base = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then check write count, timing and pulse width.
  task automatic wait_done(input int nwr, input bit chk_lat);
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      if (done_cnt > done_base) break;
    end
    #1;
    check_value("done_seen", 256'(done_cnt - done_base), 256'(1));
    check_value("wr_count", 256'(wr_cnt - wr_base), 256'(nwr));
    check_value("sb_empty", 256'(exp_q.size()), 256'(0));
    if (nwr > 0) begin
      check_value("done_after_wr", 256'(done_cyc - last_wr_cyc), 256'(1));
      if (chk_lat) begin
        check_value("first_wr_lat", 256'(first_wr_cyc - start_cyc), 256'(2));
        check_value("throughput", 256'(last_wr_cyc - first_wr_cyc), 256'(nwr - 1));
      end
    end else begin
      check_value("zero_done_lat", 256'(done_cyc - start_cyc), 256'(2));
    end
    @(negedge clk);
    check_value("done_pulse_w", 256'(done), 256'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check_value({tag, "_write"}, 256'(mwrite), 256'(0));
    check_value({tag, "_cs"}, 256'(cs), 256'(0));
    check_value({tag, "_done"}, 256'(done), 256'(0));
    check_value({tag, "_addr"}, 256'(maddr), 256'(0));
    check_value({tag, "_be"}, 256'(mbe), 256'(0));
    check_value({tag, "_data"}, mdata, 256'(0));
    check_value({tag, "_ready"}, 256'(wready), 256'(1));
    check_value({tag, "_clkena"}, 256'(clk_ena), 256'(1));
  endtask

  initial begin
    bit ok;
    int acc;
    logic r;
    rst_n = 1'b0;
    start = 1'b0;
    start_addr = 18'd0;
    to_write = 32'd0;
    wvalid = 1'b0;
    wdata = 256'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Aligned job: words 2 and 3, full enables.
    send_beats(2);
    exp_wr(13'd2, 32'hFFFF_FFFF);
    exp_wr(13'd3, 32'hFFFF_FFFF);
    start_job(18'h00040, 32'd64);
    wait_done(2, 1'b1);

    // Unaligned at both ends.
    send_beats(2);
    exp_wr(13'd1, 32'hFFFF_FFE0);
    exp_wr(13'd2, 32'h0000_1FFF);
    start_job(18'h00025, 32'd40);
    wait_done(2, 1'b1);

    // Zero count with one beat buffered: no write, beat kept.
    send_beats(1);
    start_job(18'h00100, 32'd0);
    wait_done(0, 1'b0);

    // Single-beat interior job consumes the kept beat.
    exp_wr(13'd8, 32'h0000_0078);
    start_job(18'h00103, 32'd4);
    wait_done(1, 1'b1);

    // Back-pressure: 20 beats offered, 16 accepted.
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      send_beat(ok);
      acc += int'(ok);
    end
    check_value("bp_accepted", 256'(acc), 256'(16));
    @(negedge clk);
    r = wready;
    check_value("bp_ready_low", 256'(r), 256'(0));
    @(posedge clk);
    #1;

    // Address wrap 8191 -> 0 -> 1; 13 beats remain afterwards.
    exp_wr(13'd8191, 32'hFFFF_FFFF);
    exp_wr(13'd0, 32'hFFFF_FFFF);
    exp_wr(13'd1, 32'hFFFF_FFFF);
    start_job(18'h3FFE0, 32'd96);
    wait_done(3, 1'b1);
    check_value("ready_after_wrap", 256'(wready), 256'(1));

    // Drain the 13 leftover beats.
    for (int i = 0; i < 13; i++) exp_wr(13'd100 + 13'(i), 32'hFFFF_FFFF);
    start_job(18'(100 * 32), 32'd416);
    wait_done(13, 1'b1);

    // Reset mid-job after the first write.
    send_beats(4);
    for (int i = 0; i < 4; i++) exp_wr(13'd16 + 13'(i), 32'hFFFF_FFFF);
    start_job(18'h00200, 32'd128);
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      if (wr_cnt > wr_base) break;
    end
    check_value("mid_first_wr", 256'(wr_cnt - wr_base), 256'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    exp_q.delete();
    beat_q.delete();
    done_base = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_base = wr_cnt;
    repeat (6) @(posedge clk);
    #1;
    check_value("midrst_no_done", 256'(done_cnt - done_base), 256'(0));
    check_value("midrst_no_wr", 256'(wr_cnt - wr_base), 256'(0));

    // Flushed buffer: a new job stalls until a fresh beat arrives.
    start_job(18'h00000, 32'd32);
    repeat (5) @(posedge clk);
    #1;
    check_value("flush_stall", 256'(wr_cnt - wr_base), 256'(0));
    send_beats(1);
    exp_wr(13'd0, 32'hFFFF_FFFF);
    wait_done(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onchip_mem_usr_writer.md
# onchip_mem_usr_writer

Write-side companion of the on-chip memory user logic: accepts a byte-granular write job (18-bit byte start address and byte count) plus a stream of 256-bit data beats. It buffers the beats in a small FIFO and issues one 256-bit write per beat to the 13-bit-word on-chip memory port. Per-beat byte enables are derived from the start offset and the remaining length. It sits between the host/DMA data path and the on-chip RAM, opposite the existing read path.

## Interface
- FIFO_DEPTH, 16: input beat buffer depth (power of two, ≥4).
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous and active-low.
- onchip_mem_start_addr_in  in  18  byte start address; [17:5] word address, [4:0] lane offset.
- to_write_byte_in  in  32  byte count of the job.
- onchip_mem_write_start_in  in  1  one-cycle job start pulse.
- onchip_mem_write_done_out  out  1  one-cycle job-complete pulse.
- write_data_in  in  256  data beat, 32-bit words in swapped (big-endian) order.
- write_data_valid_in  in  1  beat valid.
- write_data_ready_out  out  1  buffer can accept a beat (not full).
- onchip_mem_chip_select  out  1  high while a write is issued.
- onchip_mem_clk_ena  out  1  constant 1.
- onchip_mem_write  out  1  write strobe.
- onchip_mem_addr  out  13  word address.
- onchip_mem_write_data  out  256  little-endian write data.
- onchip_mem_byteenable  out  32  bit i enables bytes [8i+7:8i].

## Operation
- A beat is pushed when write_data_valid_in & write_data_ready_out. Beats are buffered independently of job state.
- FSM states: IDLE, WRITE, DONE.
- IDLE: on start pulse, latch word addr = start[17:5], off = start[4:0], and left = to_write_byte_in. If the count is 0, go to DONE with no writes. Otherwise go to WRITE with first = 1.
- WRITE: when the FIFO is non-empty, pop one beat and issue one write at the current addr.
  - Mask: lo = first ? off : 0. avail = 32 − lo. n = min(left, avail). Enable bits lo … lo+n−1.
  - Update: left ← left − n, addr ← addr+1 (13-bit wrap from 8191 to 0), first ← 0.
  - If left − n == 0, go to DONE.
- DONE: pulse onchip_mem_write_done_out for one cycle, then go to IDLE.
- Start pulses outside IDLE are ignored.
- Beats are consumed only inside a job. Beats beyond the count needed, ceil((off+len)/32), stay buffered for the next job.
- Arithmetic: left is 32-bit unsigned and never underflows, because n ≤ left.

## Timing
- Reset values: all outputs 0 except onchip_mem_clk_ena = 1 and write_data_ready_out = 1. FIFO empty, FSM in IDLE.
- Start accepted in IDLE → WRITE the next cycle. The first write is issued in the same cycle WRITE sees the FIFO non-empty, as a registered output visible the following edge.
- Throughput: one write per cycle while the FIFO is non-empty. Memory write latency is zero; there is no back-pressure from memory.
- Done pulse is asserted the cycle after the last write strobe. A zero-length job pulses done 2 cycles after start.
- Push and pop in the same cycle on a full FIFO: the push is refused, because ready reflects the full flag registered at the cycle start.
- Reset mid-job: the job is aborted immediately, the buffer is flushed, and no done pulse is generated.

## Configuration
- ONCHIP_MEM_WR_SWAP_EN defined: 32-bit word order is reversed from input to memory (input [255:224] → memory [31:0], and so on), matching the big-endian format of the read path.
- Undefined: write_data_in goes to onchip_mem_write_data unmodified. Byte enables are identical in both builds.

## Structure
- Shared package onchip_mem_pkg holds:
  - constants MEM_ADDR_W = 13, MEM_DATA_W = 256, MEM_BE_W = 32, BYTE_ADDR_W = 18;
  - the FSM state typedef;
  - the function mask(lo, n) → 32-bit enable.
- One sub-module, onchip_mem_wr_fifo: synchronous FIFO (256-bit, FIFO_DEPTH) with full/empty flags and show-ahead output.

## Test plan
- Aligned job: start 0x00040, count 64, 2 beats → writes at word 2 and word 3, each with byteenable 0xFFFFFFFF; done pulse 1 cycle after the second write.
- Unaligned both ends: start 0x00025, count 40 → word 1 with BE 0xFFFFFFE0, then word 2 with BE 0x00001FFF; 2 beats consumed.
- Single-beat interior: start 0x00103, count 4 → one write at word 8 with BE 0x00000078.
- Zero count: start with count 0 → no write strobe; done 2 cycles after start; buffered beats untouched.
- Wrap and back-pressure: start 0x3FFE0, count 96, upstream sends 20 beats with no job running → ready drops after 16 accepted; writes go to words 8191, 0, 1; 13 beats remain.
- Reset mid-job: assert rst_n low after the first write of a 4-beat job → outputs return to reset values at once; no done pulse; FIFO empty after release.
